// File: rtl/somador_subtrator_pipe.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshake and ALU flags.
// The WIDTH-bit carry chain is cut into STAGES segments of WIDTH/STAGES bits, one register level each.
module somador_subtrator_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             subtraindo,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);
    localparam int SEG = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("somador_subtrator_pipe: WIDTH must be a positive multiple of STAGES");
    end

    // One segment of the carry chain: {carry_out, sum}.
    function automatic logic [SEG:0] seg_add(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           cin
    );
        return {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    endfunction

    logic advance_s;

    // The whole pipeline moves as one; a held result freezes every stage, bubbles included.
    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO      = k * SEG;
        localparam int DONE    = LO + SEG;
        localparam bit IS_LAST = (k == STAGES - 1);

        logic [WIDTH-LO-1:0] op_a_s;
        logic [WIDTH-LO-1:0] op_b_s;
        logic                carry_in_s;
        logic                valid_in_s;
        logic                zero_in_s;
        logic [DONE-1:0]     res_in_s;
        logic [SEG:0]        sum_s;
        logic                load_s;

        logic                valid_q, valid_d;
        logic                carry_q, carry_d;
        logic                zero_q,  zero_d;
        logic [DONE-1:0]     res_q,   res_d;

        if (k == 0) begin : g_src
            assign op_a_s     = A;
            assign op_b_s     = B ^ {WIDTH{subtraindo}};
            assign carry_in_s = subtraindo;
            assign valid_in_s = in_valid;
            assign zero_in_s  = 1'b1;
            assign res_in_s   = sum_s[SEG-1:0];
        end else begin : g_src
            assign op_a_s     = g_stage[k-1].g_fwd.a_q;
            assign op_b_s     = g_stage[k-1].g_fwd.b_q;
            assign carry_in_s = g_stage[k-1].carry_q;
            assign valid_in_s = g_stage[k-1].valid_q;
            assign zero_in_s  = g_stage[k-1].zero_q;
            assign res_in_s   = {sum_s[SEG-1:0], g_stage[k-1].res_q};
        end

        assign sum_s = seg_add(op_a_s[SEG-1:0], op_b_s[SEG-1:0], carry_in_s);

        // The output stage only takes real entries, so S and flags never change on a bubble.
        assign load_s = advance_s && (valid_in_s || !IS_LAST);

        // Next-state for this segment's valid bit, carry, running zero and completed result bits.
        always_comb begin
            valid_d = valid_q;
            carry_d = carry_q;
            zero_d  = zero_q;
            res_d   = res_q;
            if (advance_s) begin
                valid_d = valid_in_s;
            end else begin
                valid_d = valid_q;
            end
            if (load_s) begin
                carry_d = sum_s[SEG];
                zero_d  = zero_in_s && (sum_s[SEG-1:0] == {SEG{1'b0}});
                res_d   = res_in_s;
            end else begin
                carry_d = carry_q;
                zero_d  = zero_q;
                res_d   = res_q;
            end
        end

        // Segment state registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                zero_q  <= 1'b0;
                res_q   <= {DONE{1'b0}};
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                zero_q  <= zero_d;
                res_q   <= res_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int REM = WIDTH - DONE;

            logic [REM-1:0] a_q, a_d;
            logic [REM-1:0] b_q, b_d;

            // Operand bits not yet consumed travel with their entry.
            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (advance_s) begin
                    a_d = op_a_s[WIDTH-LO-1:SEG];
                    b_d = op_b_s[WIDTH-LO-1:SEG];
                end else begin
                    a_d = a_q;
                    b_d = b_q;
                end
            end

            // Forwarded operand registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= {REM{1'b0}};
                    b_q <= {REM{1'b0}};
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_ovf
            logic ovf_q, ovf_d;
            logic carry_msb_s;

            // Carry into the MSB recovered from the MSB's own sum bit.
            assign carry_msb_s = op_a_s[SEG-1] ^ op_b_s[SEG-1] ^ sum_s[SEG-1];

            // Signed overflow: carry into MSB differs from carry out of MSB.
            always_comb begin
                ovf_d = ovf_q;
                if (load_s) begin
                    ovf_d = carry_msb_s ^ sum_s[SEG];
                end else begin
                    ovf_d = ovf_q;
                end
            end

            // Overflow flag register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign S         = g_stage[STAGES-1].res_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign zero      = g_stage[STAGES-1].zero_q;
    assign negative  = S[WIDTH-1];
    assign overflow  = g_stage[STAGES-1].g_ovf.ovf_q;

endmodule
